// File: rtl/genscope_monitor.sv
// rtl/genscope_monitor.sv - sequence monitor for the genscope counter stream
module genscope_monitor #(
   parameter int GEN      = 1,
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             VALID,
   output logic             LOCKED,
   output logic             DIR,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [WIDTH-1:0] LAST
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACQ  = 2'd1,
      S_LOCK = 2'd2
   } state_t;

   localparam logic             DIR_RST = (GEN == 1);
   localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
   localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
   localparam logic [WIDTH-1:0] STEP_DN = {WIDTH{1'b1}};
   localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

   // Parameter sanity: reject unsupported direction modes and lock lengths
   if (GEN < 0 || GEN > 2) begin : g_gen_chk
      $error("genscope_monitor: GEN must be 0, 1 or 2");
   end
   if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_lock_chk
      $error("genscope_monitor: LOCK_CNT must be in 1..15");
   end

   state_t             state, state_n;
   logic [3:0]         gcnt, gcnt_n;
   logic               dir_n;
   logic               err_n;
   logic [ERR_W-1:0]   cnt_n;
   logic [WIDTH-1:0]   last_n;
   logic [WIDTH-1:0]   delta;
   logic               step_up, step_dn, step_fwd;

   // Modular distance from the last accepted sample; wrap steps fall out naturally
   assign delta    = D - LAST;
   assign step_up  = (delta == STEP_UP);
   assign step_dn  = (delta == STEP_DN);
   assign step_fwd = DIR ? step_dn : step_up;

   // Next-state and next-status decode; everything holds while VALID is low
   always_comb begin
      state_n = state;
      gcnt_n  = gcnt;
      dir_n   = DIR;
      err_n   = 1'b0;
      cnt_n   = ERR_CNT;
      last_n  = LAST;
      if (VALID) begin
         last_n = D;
         case (state)
            S_IDLE: begin
               state_n = S_ACQ;
               gcnt_n  = 4'd0;
            end
            S_ACQ: begin
               // Auto mode resolves direction from the first unit step of a run
               if (GEN == 2 && gcnt == 4'd0 && (step_up || step_dn)) begin
                  dir_n  = step_dn;
                  gcnt_n = 4'd1;
                  if (LOCK_V == 4'd1) begin
                     state_n = S_LOCK;
                  end
               end else if (step_fwd) begin
                  gcnt_n = gcnt + 4'd1;
                  if (gcnt + 4'd1 == LOCK_V) begin
                     state_n = S_LOCK;
                  end
               end else begin
                  gcnt_n = 4'd0;
               end
            end
            S_LOCK: begin
               // Any break in lock, a hold included, is a violation
               if (!step_fwd) begin
                  err_n   = 1'b1;
                  state_n = S_ACQ;
                  gcnt_n  = 4'd0;
                  if (ERR_CNT != CNT_MAX) begin
                     cnt_n = ERR_CNT + ERR_W'(1);
                  end
               end
            end
            default: begin
               state_n = S_IDLE;
               gcnt_n  = 4'd0;
            end
         endcase
      end
   end

   // State and status registers; reset discards any sample presented with it
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         gcnt    <= 4'd0;
         LOCKED  <= 1'b0;
         DIR     <= DIR_RST;
         ERR     <= 1'b0;
         ERR_CNT <= '0;
         LAST    <= '0;
      end else begin
         state   <= state_n;
         gcnt    <= gcnt_n;
         LOCKED  <= (state_n == S_LOCK);
         DIR     <= dir_n;
         ERR     <= err_n;
         ERR_CNT <= cnt_n;
         LAST    <= last_n;
      end
   end

endmodule

// File: doc/genscope_monitor.md
# genscope_monitor

Sequence monitor for the counter stream produced by `genscope`. It samples the 4-bit count on a qualified cycle, acquires lock once enough consecutive unit steps in the expected direction are seen, and from then on flags every sample that breaks the sequence. It sits beside the counter in test builds and drives status/error bits to the debug register bank.

## Interface
- `GEN`, default 1: expected direction. 0 = increment, 1 = decrement, 2 = auto-detect from the first step. Any other value raises an elaboration-time `$error`.
- `WIDTH`, default 4: width of the observed count.
- `LOCK_CNT`, default 3: number of consecutive good steps required to lock. Legal range 1..15.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `CLK`, input, 1: the single clock. All logic is on the rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `D`, input, WIDTH: observed counter value.
- `VALID`, input, 1: `D` is sampled only on cycles where this is high.
- `LOCKED`, output, 1: the monitor is in the LOCK state.
- `DIR`, output, 1: resolved direction, 0 = up, 1 = down.
- `ERR`, output, 1: one-cycle pulse per sequence violation.
- `ERR_CNT`, output, ERR_W: count of violations; saturates at all-ones.
- `LAST`, output, WIDTH: the most recently accepted sample.

## Operation
- **Step definition.** A sample is a step when `VALID` is high. The step delta is `D - LAST` modulo 2^WIDTH.
  - Good up step: delta = 1, so 15→0 counts as good.
  - Good down step: delta = all-ones, so 0→15 counts as good.
- **States:** IDLE, ACQ, LOCK. The state is held on any cycle where `VALID` is low.
- **IDLE**
  - On a valid sample: `LAST <= D`, go to ACQ, good-count = 0.
- **ACQ**
  - Good step in the expected direction: good-count + 1. When good-count reaches `LOCK_CNT`, go to LOCK.
  - Any other delta: good-count = 0, stay in ACQ. `ERR` is not asserted.
  - With `GEN`=2 and good-count = 0: a delta of +1 or −1 sets `DIR` and counts as good. Once good-count > 0, only steps matching `DIR` are good.
- **LOCK**
  - Good step: stay in LOCK.
  - Bad step, including delta 0 (hold):
    - `ERR` pulses and `ERR_CNT` increments, saturating.
    - Go to ACQ with good-count = 0.
    - With `GEN`=2, `DIR` re-resolves on the next step.
- `LAST <= D` on every valid sample, in every state.
- With `GEN`=0 or 1, `DIR` is the constant `GEN[0]` after reset.
- **Reset:** state = IDLE, good-count = 0, `LOCKED`=0, `ERR`=0, `ERR_CNT`=0, `LAST`=0. `DIR`=0 for `GEN`=0 or 2; `DIR`=1 for `GEN`=1.
- **`RST` together with `VALID`:** reset wins and the sample is discarded.
- **Reset while in LOCK:** all status clears, and the next valid sample re-enters IDLE→ACQ.

## Timing
- All outputs are registered. Status reflects the sample seen on the previous valid edge.
- `ERR` is high for exactly the one cycle after the offending sample's edge. It is never high on two consecutive cycles unless two consecutive valid bad samples occur, which is impossible because the first one drops to ACQ.
- `LOCKED` rises on the cycle after the `LOCK_CNT`-th good step, i.e. after `LOCK_CNT`+1 valid samples from IDLE.
- `LOCKED` falls on the same cycle `ERR` pulses.
- Gaps in `VALID` do not break a sequence; only accepted samples are compared.

## Test plan
- **Up counter lock:** `GEN`=0, `VALID`=1, `D` = 0,1,2,3 → `LOCKED`=1 one cycle after `D`=3. `ERR`=0, `ERR_CNT`=0.
- **Down wrap:** `GEN`=1, `D` = 1,0,15,14,13 → lock after 14. Stays locked through 0→15 with no `ERR`.
- **Violation:** locked up stream 4,5,6, then `D`=9 → `ERR` pulses once, `ERR_CNT`=1, `LOCKED`=0. The following stream 10,11,12 relocks.
- **Hold in LOCK:** locked, `D`=7,7 → `ERR` pulse, `ERR_CNT` increments.
- **Auto-detect:** `GEN`=2, `D` = 8,7,6,5 → `DIR`=1, `LOCKED`=1. Then `D` = 6 → `ERR` pulses. Then `D` = 7,8,9,10 → `DIR`=0, relocked.
- **Saturation and reset:** `ERR_W`=2, force 5 violations → `ERR_CNT`=3. Assert `RST` with `VALID`=1 → all outputs at reset values the next cycle, and the sample is ignored.
